// File: rtl/multi_sample_fetcher_if.sv
// multi_sample_fetcher_if: memory read port plus per-channel base and chunk handshakes of the sample fetcher
interface multi_sample_fetcher_if #(
  parameter int NUM_CH = 4,
  parameter int CHUNKS_PER_BUF = 64,
  parameter int ADDR_W = 29
);
  localparam int BASE_W = ADDR_W - $clog2(CHUNKS_PER_BUF);
  logic [ADDR_W-1:0] o_mem_addr;
  logic o_mem_read_en;
  logic [63:0] i_mem_data;
  logic i_mem_ack;
  logic [NUM_CH*BASE_W-1:0] i_base;
  logic [NUM_CH-1:0] i_base_valid;
  logic [NUM_CH-1:0] o_base_ack;
  logic [NUM_CH*64-1:0] o_chunk;
  logic [NUM_CH-1:0] o_chunk_valid;
  logic [NUM_CH-1:0] i_chunk_ack;
  logic [NUM_CH-1:0] o_buf_done;
  modport master (
    output o_mem_addr, o_mem_read_en, o_base_ack, o_chunk, o_chunk_valid, o_buf_done,
    input i_mem_data, i_mem_ack, i_base, i_base_valid, i_chunk_ack
  );
  modport slave (
    input o_mem_addr, o_mem_read_en, o_base_ack, o_chunk, o_chunk_valid, o_buf_done,
    output i_mem_data, i_mem_ack, i_base, i_base_valid, i_chunk_ack
  );
endinterface

// File: rtl/multi_sample_fetcher.sv
// multi_sample_fetcher: round-robin refill of per-channel 64-bit chunk storage through one outstanding memory read.
// Define SAMPLE_FETCHER_PREFETCH_EN to give every channel a 2-entry FIFO instead of a single slot.
module multi_sample_fetcher #(
  parameter int NUM_CH = 4,
  parameter int CHUNKS_PER_BUF = 64,
  parameter int ADDR_W = 29
) (
  input logic clk,
  input logic rst,
  multi_sample_fetcher_if.master bus
);
  localparam int CIDX_W = $clog2(CHUNKS_PER_BUF);
  localparam int BASE_W = ADDR_W - CIDX_W;
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic {IDLE, READ_WAIT} state_t;
  state_t r_state;
  logic [CH_W-1:0] r_gnt, r_rr, w_g;
  logic [NUM_CH-1:0] r_active, w_elig, w_push, w_pop, w_valid, w_base_ack;
  logic [BASE_W-1:0] r_base [NUM_CH];
  logic [CIDX_W-1:0] r_cidx [NUM_CH];
  logic w_any, w_issue, w_last;
  // first eligible channel at or after the round-robin pointer
  always_comb begin
    logic [CH_W:0] j;
    w_any = 1'b0;
    w_g = '0;
    j = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      j = {1'b0, r_rr} + (CH_W+1)'(k);
      if (j >= (CH_W+1)'(NUM_CH)) j = j - (CH_W+1)'(NUM_CH);
      if (w_elig[j[CH_W-1:0]]) begin
        w_any = 1'b1;
        w_g = j[CH_W-1:0];
      end
    end
  end
  assign w_issue = ~rst & (r_state == IDLE) & w_any;
  assign w_last = r_cidx[w_g] == CIDX_W'(CHUNKS_PER_BUF - 1);
  assign w_base_ack = rst ? '0 : bus.i_base_valid & ~r_active;
  assign bus.o_mem_read_en = w_issue;
  assign bus.o_mem_addr = w_issue ? {r_base[w_g], r_cidx[w_g]} : '0;
  assign bus.o_buf_done = (w_issue & w_last) ? NUM_CH'(1) << w_g : '0;
  assign bus.o_base_ack = w_base_ack;
  assign bus.o_chunk_valid = w_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt <= '0;
      r_rr <= '0;
      r_active <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_base[i] <= '0;
        r_cidx[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_base_ack[i]) begin
          r_base[i] <= bus.i_base[i*BASE_W +: BASE_W];
          r_active[i] <= 1'b1;
          r_cidx[i] <= '0;
        end
      end
      if (w_issue) begin
        r_state <= READ_WAIT;
        r_gnt <= w_g;
        r_rr <= (int'(w_g) == NUM_CH - 1) ? '0 : w_g + 1'b1;
        r_cidx[w_g] <= r_cidx[w_g] + 1'b1;
        if (w_last) r_active[w_g] <= 1'b0;
      end else if (r_state == READ_WAIT && bus.i_mem_ack) begin
        r_state <= IDLE;
      end
    end
  end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [63:0] r_head;
    assign w_push[i] = (r_state == READ_WAIT) & bus.i_mem_ack & (r_gnt == CH_W'(i));
    assign w_pop[i] = bus.i_chunk_ack[i] & w_valid[i];
    assign bus.o_chunk[i*64 +: 64] = r_head;
`ifdef SAMPLE_FETCHER_PREFETCH_EN
    logic [63:0] r_skid;
    logic [1:0] r_cnt;
    assign w_valid[i] = r_cnt != 2'd0;
    assign w_elig[i] = r_active[i] & ~r_cnt[1];
    // a full FIFO only takes a push together with a pop, so the skid entry shifts up
    always_ff @(posedge clk) begin
      if (rst) begin
        r_head <= '0;
        r_skid <= '0;
        r_cnt <= '0;
      end else begin
        if (w_pop[i] & r_cnt[1]) r_head <= r_skid;
        if (w_push[i] & ((r_cnt == 2'd0) | ((r_cnt == 2'd1) & w_pop[i]))) r_head <= bus.i_mem_data;
        if (w_push[i] & ((r_cnt == 2'd2) | ((r_cnt == 2'd1) & ~w_pop[i]))) r_skid <= bus.i_mem_data;
        r_cnt <= r_cnt + {1'b0, w_push[i]} - {1'b0, w_pop[i]};
      end
    end
`else
    logic r_valid;
    assign w_valid[i] = r_valid;
    assign w_elig[i] = r_active[i] & ~r_valid;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_head <= '0;
        r_valid <= 1'b0;
      end else begin
        if (w_push[i]) r_head <= bus.i_mem_data;
        r_valid <= w_push[i] | (r_valid & ~w_pop[i]);
      end
    end
`endif
  end
endmodule
